// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : led_pkg                                                    |
// | Brief   : shared mode encodings and helpers for led_pattern_engine   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package led_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_BOUNCE    = 3'd0;
  localparam logic [MODE_W-1:0] MODE_FILL      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_CONVERGE  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ALT       = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROTATE    = 3'd4;
  localparam logic [MODE_W-1:0] MODE_AUTO_LAST = 3'd4;

  // Auto-cycle order 0->1->2->3->4->0.
  function automatic logic [MODE_W-1:0] next_auto_mode(input logic [MODE_W-1:0] mode);
    return (mode >= MODE_AUTO_LAST) ? MODE_BOUNCE : mode + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : step_tick                                                  |
// | Brief   : pausable prescaler; tick every step_div+1 clocks           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module step_tick #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             clear,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  // >= rather than == so lowering step_div mid-count wraps at once.
  assign tick = !pause && (div_cnt >= step_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (!pause) begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : led_pattern_engine                                         |
// | Brief   : N-wide LED bar animator, five patterns, auto-cycle, mirror |
// |           optional PWM dimming when LED_PWM_EN is defined            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int N_LEDS  = 26,
  parameter int WIN     = 3,
  parameter int DIV_W   = 26,
  parameter int REPEATS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              auto_i,
  input  logic              pause_i,
  input  logic              dir_i,
  input  logic [DIV_W-1:0]  step_div,
`ifdef LED_PWM_EN
  input  logic [3:0]        duty,
`endif
  output logic [N_LEDS-1:0] led_o,
  output logic [MODE_W-1:0] active_mode,
  output logic              pattern_done
);

  localparam int K_W   = $clog2(2 * N_LEDS);
  localparam int IDX_W = $clog2(N_LEDS);
  localparam int H     = (N_LEDS + 1) / 2;
  localparam int REP_W = (REPEATS > 1) ? $clog2(REPEATS + 1) : 1;

  localparam logic [K_W-1:0]   K_ONE       = K_W'(1);
  localparam logic [K_W-1:0]   K_N         = K_W'(N_LEDS);
  localparam logic [K_W-1:0]   K_H         = K_W'(H);
  localparam logic [K_W-1:0]   K_PEAK      = K_W'(N_LEDS - WIN);
  localparam logic [K_W-1:0]   K_FILL_LAST = K_W'(2 * N_LEDS - 1);
  localparam logic [K_W-1:0]   K_CONV_LAST = K_W'(2 * H - 1);
  localparam logic [K_W-1:0]   K_ROT_LAST  = K_W'(N_LEDS - 1);
  localparam logic [REP_W-1:0] REP_MAX     = REP_W'(REPEATS);

  localparam logic [2*N_LEDS-1:0] ALT_PAIRS = {N_LEDS{2'b10}};
  localparam logic [N_LEDS-1:0]   ODD_MASK  = ALT_PAIRS[N_LEDS-1:0];
  localparam logic [N_LEDS-1:0]   WIN_MASK  = {{(N_LEDS-WIN){1'b0}}, {WIN{1'b1}}};
  localparam logic [N_LEDS-1:0]   DOT       = {{(N_LEDS-1){1'b0}}, 1'b1};

  logic [N_LEDS-1:0] state, state_d;
  logic [K_W-1:0]    k, k_d, pair_k;
  logic [IDX_W-1:0]  lo_idx, hi_idx;
  logic              flag, flag_d;
  logic [REP_W-1:0]  rep, rep_d;
  logic [MODE_W-1:0] mode_d;
  logic              done_d, clear, tick;
  logic [N_LEDS-1:0] gate, gated, mirrored, led_d;

  step_tick #(.DIV_W(DIV_W)) u_step_tick (
    .clk      (clk),
    .reset    (reset),
    .pause    (pause_i),
    .clear    (clear),
    .step_div (step_div),
    .tick     (tick)
  );

  always_comb begin
    state_d = state;
    k_d     = k;
    flag_d  = flag;
    rep_d   = rep;
    mode_d  = active_mode;
    done_d  = 1'b0;
    clear   = 1'b0;
    pair_k  = '0;
    lo_idx  = '0;
    hi_idx  = '0;

    if (auto_i) begin
      if (active_mode > MODE_AUTO_LAST) begin
        mode_d = MODE_BOUNCE;
        clear  = 1'b1;
      end else if (rep >= REP_MAX) begin
        mode_d = next_auto_mode(active_mode);
        clear  = 1'b1;
      end
    end else if (mode_i != active_mode) begin
      mode_d = mode_i;
      clear  = 1'b1;
    end

    // A mode change swallows any tick landing on the same clock.
    if (clear) begin
      state_d = '0;
      k_d     = '0;
      flag_d  = 1'b0;
      rep_d   = '0;
    end else if (tick) begin
      case (active_mode)
        MODE_BOUNCE: begin
          // k is the window position; flag marks the falling half.
          state_d = WIN_MASK << k;
          if (!flag && (k != K_PEAK)) begin
            k_d = k + K_ONE;
          end else begin
            k_d    = k - K_ONE;
            done_d = (k == K_ONE);
            flag_d = (k != K_ONE);
          end
        end
        MODE_FILL: begin
          if (k < K_N) begin
            lo_idx          = IDX_W'(k);
            state_d[lo_idx] = 1'b1;
          end else begin
            lo_idx          = IDX_W'(k - K_N);
            state_d[lo_idx] = 1'b0;
          end
          done_d = (k == K_FILL_LAST);
          k_d    = done_d ? '0 : k + K_ONE;
        end
        MODE_CONVERGE: begin
          pair_k          = (k < K_H) ? k : k - K_H;
          lo_idx          = IDX_W'(pair_k);
          hi_idx          = IDX_W'(K_N - K_ONE - pair_k);
          state_d[lo_idx] = (k < K_H);
          state_d[hi_idx] = (k < K_H);
          done_d          = (k == K_CONV_LAST);
          k_d             = done_d ? '0 : k + K_ONE;
        end
        MODE_ALT: begin
          state_d = k[0] ? ~ODD_MASK : ODD_MASK;
          done_d  = k[0];
          k_d     = k[0] ? '0 : K_ONE;
        end
        MODE_ROTATE: begin
          state_d = DOT << k;
          done_d  = (k == K_ROT_LAST);
          k_d     = done_d ? '0 : k + K_ONE;
        end
        default: begin
          state_d = '1;
        end
      endcase
      if (done_d && auto_i && (rep < REP_MAX)) begin
        rep_d = rep + REP_W'(1);
      end
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign gate = {N_LEDS{(pwm_cnt < duty) || (duty == 4'hF)}};
`else
  assign gate = '1;
`endif

  assign gated = state_d & gate;

  always_comb begin
    mirrored = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      mirrored[i] = gated[N_LEDS-1-i];
    end
  end

  assign led_d = dir_i ? mirrored : gated;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= '0;
      k            <= '0;
      flag         <= 1'b0;
      rep          <= '0;
      active_mode  <= MODE_BOUNCE;
      pattern_done <= 1'b0;
      led_o        <= '0;
    end else begin
      state        <= state_d;
      k            <= k_d;
      flag         <= flag_d;
      rep          <= rep_d;
      active_mode  <= mode_d;
      pattern_done <= done_d;
      led_o        <= led_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_led_pattern_engine                                      |
// | Brief   : scoreboard bench with closed-form pattern reference model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_led_pattern_engine;

  localparam int N       = 26;
  localparam int WIN     = 3;
  localparam int DIV_W   = 26;
  localparam int REPEATS = 1;
  localparam int H       = (N + 1) / 2;

  logic             clk      = 1'b0;
  logic             reset    = 1'b0;
  logic [2:0]       mode_i   = 3'd0;
  logic             auto_i   = 1'b0;
  logic             pause_i  = 1'b0;
  logic             dir_i    = 1'b0;
  logic [DIV_W-1:0] step_div = '0;
`ifdef LED_PWM_EN
  logic [3:0]       duty     = 4'hF;
`endif
  logic [N-1:0]     led_o;
  logic [2:0]       active_mode;
  logic             pattern_done;

  led_pattern_engine #(.N_LEDS(N), .WIN(WIN), .DIV_W(DIV_W), .REPEATS(REPEATS)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode_i       (mode_i),
    .auto_i       (auto_i),
    .pause_i      (pause_i),
    .dir_i        (dir_i),
    .step_div     (step_div),
`ifdef LED_PWM_EN
    .duty         (duty),
`endif
    .led_o        (led_o),
    .active_mode  (active_mode),
    .pattern_done (pattern_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] led;
    logic [2:0]   mode;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cycle_len(input int m);
    case (m)
      0:       return 2 * (N - WIN);
      1:       return 2 * N;
      2:       return 2 * H;
      3:       return 2;
      default: return N;
    endcase
  endfunction

  // LED image after s ticks since the last clear, from the pattern rules.
  function automatic logic [N-1:0] image(input int m, input int s);
    logic [N-1:0] v;
    int j, p, d;
    v = '0;
    if (s == 0) return v;
    if (m > 4) return '1;
    j = (s - 1) % cycle_len(m);
    p = (j <= N - WIN) ? j : 2 * (N - WIN) - j;
    for (int i = 0; i < N; i++) begin
      d = (i < N - 1 - i) ? i : N - 1 - i;
      case (m)
        0:       v[i] = (i >= p) && (i < p + WIN);
        1:       v[i] = (j < N) ? (i <= j) : (i > j - N);
        2:       v[i] = (j < H) ? (d <= j) : (d > j - H);
        3:       v[i] = ((j % 2) == 0) ? ((i % 2) == 1) : ((i % 2) == 0);
        default: v[i] = (i == j);
      endcase
    end
    return v;
  endfunction

  function automatic logic [N-1:0] mirror(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // Reference model: one expected output per clock edge.
  initial begin : model
    int m_mode, m_s, m_rep, m_div, m_pwm, nm;
    bit change, tk, dn;
    logic [N-1:0] g;
    exp_t e;
    m_mode = 0; m_s = 0; m_rep = 0; m_div = 0; m_pwm = 0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_mode = 0; m_s = 0; m_rep = 0; m_div = 0; m_pwm = 0;
        e = '0;
      end else begin
        change = 1'b0;
        nm     = m_mode;
        dn     = 1'b0;
        if (auto_i) begin
          if (m_mode > 4) begin
            change = 1'b1; nm = 0;
          end else if (m_rep >= REPEATS) begin
            change = 1'b1; nm = (m_mode + 1) % 5;
          end
        end else if (int'(mode_i) != m_mode) begin
          change = 1'b1; nm = int'(mode_i);
        end
        if (change) begin
          m_mode = nm; m_s = 0; m_rep = 0; m_div = 0;
        end else begin
          tk = !pause_i && (m_div >= int'(step_div));
          if (!pause_i) m_div = tk ? 0 : m_div + 1;
          if (tk) begin
            m_s++;
            if (m_mode <= 4 && ((m_s - 1) % cycle_len(m_mode)) == cycle_len(m_mode) - 1) begin
              dn = 1'b1;
              if (auto_i) m_rep++;
            end
          end
        end
        g = image(m_mode, m_s);
`ifdef LED_PWM_EN
        if (!((m_pwm < int'(duty)) || (duty == 4'hF))) g = '0;
        m_pwm = (m_pwm + 1) % 16;
`endif
        e.led  = dir_i ? mirror(g) : g;
        e.mode = 3'(m_mode);
        e.done = dn;
      end
      sb.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_led", 64'(led_o), 64'(e.led));
        chk("sb_mode", 64'(active_mode), 64'(e.mode));
        chk("sb_done", 64'(pattern_done), 64'(e.done));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stimulus
    int on_cnt, r;
    cyc(3);
    chk("reset_led", 64'(led_o), 64'h0);
    chk("reset_mode", 64'(active_mode), 64'h0);
    chk("reset_done", 64'(pattern_done), 64'h0);
    reset = 1'b1;

    // Bounce
    cyc(1);  chk("bounce_t1", 64'(led_o), 64'h7);
    cyc(1);  chk("bounce_t2", 64'(led_o), 64'hE);
    cyc(43); chk("bounce_t45_nodone", 64'(pattern_done), 64'h0);
    cyc(1);  chk("bounce_t46_done", 64'(pattern_done), 64'h1);
             chk("bounce_t46_led", 64'(led_o), 64'hE);
    cyc(1);  chk("bounce_t47_led", 64'(led_o), 64'h7);

    // Fill / clear
    mode_i = 3'd1;
    cyc(1);  chk("fill_clear_led", 64'(led_o), 64'h0);
             chk("fill_mode", 64'(active_mode), 64'h1);
    cyc(26); chk("fill_t26", 64'(led_o), 64'h3FFFFFF);
    cyc(26); chk("fill_t52_led", 64'(led_o), 64'h0);
             chk("fill_t52_done", 64'(pattern_done), 64'h1);

    // Mode change concurrent with a tick
    cyc(5);
    mode_i = 3'd2;
    cyc(1);  chk("chg_led", 64'(led_o), 64'h0);
             chk("chg_mode", 64'(active_mode), 64'h2);
    cyc(1);  chk("converge_t1", 64'(led_o), 64'h2000001);

    // Prescaler
    mode_i = 3'd4; step_div = DIV_W'(4);
    cyc(1);
    cyc(4);  chk("div4_wait", 64'(led_o), 64'h0);
    cyc(1);  chk("div4_tick1", 64'(led_o), 64'h1);
    cyc(5);  chk("div4_tick2", 64'(led_o), 64'h2);
    cyc(3);
    step_div = DIV_W'(1);
    cyc(1);  chk("div_lowered", 64'(led_o), 64'h4);

    // Auto cycling from mode 3
    step_div = '0; mode_i = 3'd3;
    cyc(1);
    auto_i = 1'b1; mode_i = 3'd7;
    cyc(2);  chk("auto_alt_done", 64'(pattern_done), 64'h1);
    cyc(1);  chk("auto_adv_mode", 64'(active_mode), 64'h4);
             chk("auto_adv_led", 64'(led_o), 64'h0);
    cyc(26); chk("auto_rot_done", 64'(pattern_done), 64'h1);
    cyc(1);  chk("auto_wrap_mode", 64'(active_mode), 64'h0);

    // Static modes and entering auto from them
    auto_i = 1'b0; mode_i = 3'd6;
    cyc(1);  chk("static_mode", 64'(active_mode), 64'h6);
    cyc(2);  chk("static_led", 64'(led_o), 64'h3FFFFFF);
    auto_i = 1'b1;
    cyc(1);  chk("auto_force0", 64'(active_mode), 64'h0);
             chk("auto_force0_led", 64'(led_o), 64'h0);
    auto_i = 1'b0; mode_i = 3'd0;

    // Pause and mirror
    cyc(4);
    pause_i = 1'b1; cyc(6);
    pause_i = 1'b0; dir_i = 1'b1; cyc(6);
    dir_i = 1'b0;  cyc(4);

    // Asynchronous reset mid-pattern
    @(negedge clk); #1;
    reset = 1'b0;
    #1 chk("async_reset", 64'(led_o), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(3);

`ifdef LED_PWM_EN
    mode_i = 3'd5; duty = 4'd0;
    cyc(4);  chk("pwm_duty0", 64'(led_o), 64'h0);
    duty = 4'd8;
    on_cnt = 0;
    repeat (16) begin
      cyc(1);
      if (led_o != '0) on_cnt++;
    end
    chk("pwm_duty8_on", 64'(on_cnt), 64'd8);
    duty = 4'hF;
`endif

    // Randomised phase
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 3)   mode_i = 3'($urandom_range(0, 7));
      if (r >= 3 && r < 5) auto_i = ~auto_i;
      if (r == 10) dir_i = ~dir_i;
      if (r == 11) step_div = DIV_W'($urandom_range(0, 3));
`ifdef LED_PWM_EN
      if (r == 12) duty = 4'($urandom_range(0, 15));
`endif
      pause_i = ($urandom_range(0, 19) == 0);
      cyc(1);
    end

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
